// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core: FSM state encoding, instruction
// bit positions, the address width and the jump-condition helper.
package hack_pkg;

  // Core sequencing states; HALT is only reachable with HACK_CPU_HALT_DETECT_EN.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int ADDR_W = 15;

  // Instruction bit positions (Hack encoding: 111a cccc ccdd djjj).
  localparam int TYPE = 15;
  localparam int ABIT = 12;
  localparam int C1   = 11;
  localparam int C2   = 10;
  localparam int C3   = 9;
  localparam int C4   = 8;
  localparam int C5   = 7;
  localparam int C6   = 6;
  localparam int D1   = 5;
  localparam int D2   = 4;
  localparam int D3   = 3;
  localparam int J1   = 2;
  localparam int J2   = 1;
  localparam int J3   = 0;

  // Jump condition: j[2] = less-than, j[1] = equal, j[0] = greater-than.
  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    jump_taken = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/ALU.sv
// Team ALU. Control polarity differs from textbook Hack: f=1 selects AND,
// no=1 passes the result through un-negated.
module ALU (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z_s;
  logic [15:0] x_n_s;
  logic [15:0] y_z_s;
  logic [15:0] y_n_s;
  logic [15:0] res_s;

  // Operand conditioning, function select, output polarity and flags.
  always_comb begin
    x_z_s = 16'h0000;
    x_n_s = 16'h0000;
    y_z_s = 16'h0000;
    y_n_s = 16'h0000;
    res_s = 16'h0000;
    if (zx) x_z_s = 16'h0000; else x_z_s = x;
    if (nx) x_n_s = ~x_z_s;   else x_n_s = x_z_s;
    if (zy) y_z_s = 16'h0000; else y_z_s = y;
    if (ny) y_n_s = ~y_z_s;   else y_n_s = y_z_s;
    if (f)  res_s = x_n_s & y_n_s; else res_s = x_n_s + y_n_s;
    if (no) out = res_s; else out = ~res_s;
    zr = (out == 16'h0000);
    ng = out[15];
  end

endmodule

// File: rtl/hack_pc_unit.sv
// Program counter: holds the ROM address, advances with 15-bit wrap and
// resolves conditional jumps against the ALU flags, loading the target from A.
module hack_pc_unit
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 15'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              is_c,
  input  logic [2:0]        jump,
  input  logic              zr,
  input  logic              ng,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              take
);

  logic [ADDR_W-1:0] pc_next_s;

  // Jump resolution; A-instructions never jump.
  always_comb begin
    take      = 1'b0;
    pc_next_s = pc + 15'd1;
    if (is_c) take = jump_taken(jump, zr, ng); else take = 1'b0;
    if (take) pc_next_s = target; else pc_next_s = pc + 15'd1;
  end

  // PC register, updated only at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= pc_next_s;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/hack_cpu_core.sv
// Two-cycle Hack CPU core (FETCH, EXEC). Holds IR, A and D, drives the team
// ALU and the data-RAM interface. Optional halt-loop detection is enabled
// by defining HACK_CPU_HALT_DETECT_EN.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 15'd0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc,
  input  logic [15:0]       instruction,
  input  logic [15:0]       inM,
  output logic [15:0]       outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic              halted
);

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] ir_r;
  logic [15:0] a_r;
  logic [15:0] d_r;
  logic [15:0] alu_y_s;
  logic [15:0] alu_out_s;
  logic        alu_zr_s;
  logic        alu_ng_s;
  logic        exec_s;
  logic        is_c_s;
  logic        take_s;
  logic        halt_hit_s;

  assign exec_s = (state_r == EXEC);
  assign is_c_s = ir_r[TYPE];

  // ALU y operand: memory when the a-bit is set, otherwise the A register.
  always_comb begin
    alu_y_s = a_r;
    if (ir_r[ABIT]) alu_y_s = inM; else alu_y_s = a_r;
  end

  // f and no are inverted because the team ALU uses the opposite polarity.
  ALU u_alu (
    .x  (d_r),
    .y  (alu_y_s),
    .zx (ir_r[C1]),
    .nx (ir_r[C2]),
    .zy (ir_r[C3]),
    .ny (ir_r[C4]),
    .f  (~ir_r[C5]),
    .no (~ir_r[C6]),
    .out(alu_out_s),
    .zr (alu_zr_s),
    .ng (alu_ng_s)
  );

  // The jump target is the pre-edge A, so "A=..;JMP" goes to the old A.
  hack_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .advance(exec_s),
    .is_c   (is_c_s),
    .jump   (ir_r[J1:J3]),
    .zr     (alu_zr_s),
    .ng     (alu_ng_s),
    .target (a_r[ADDR_W-1:0]),
    .pc     (pc),
    .take   (take_s)
  );

  assign outM     = alu_out_s;
  assign addressM = a_r[ADDR_W-1:0];
  assign writeM   = exec_s & is_c_s & ir_r[D3];

`ifdef HACK_CPU_HALT_DETECT_EN
  logic prev_was_a_r;

  // "@X; 0;JMP" at X+1 jumps back onto its own A-load: a terminal loop.
  assign halt_hit_s = exec_s & take_s & prev_was_a_r &
                      (a_r[ADDR_W-1:0] == (pc - 15'd1));

  // Remember whether the last executed instruction was an A-instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_was_a_r <= 1'b0;
    end else if (exec_s) begin
      prev_was_a_r <= ~is_c_s;
    end else begin
      prev_was_a_r <= prev_was_a_r;
    end
  end

  assign halted = (state_r == HALT);
`else
  assign halt_hit_s = 1'b0;
  assign halted     = 1'b0;
`endif

  // Next-state logic for the FETCH/EXEC/HALT sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH:   state_next_s = EXEC;
      EXEC: begin
        if (halt_hit_s) state_next_s = HALT; else state_next_s = FETCH;
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = FETCH;
    endcase
  end

  // State register; reset overrides everything, including a pending EXEC.
  always_ff @(posedge clk) begin
    if (reset) state_r <= FETCH;
    else       state_r <= state_next_s;
  end

  // Instruction register loads at the end of FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_r <= 16'h0000;
    end else if (state_r == FETCH) begin
      ir_r <= instruction;
    end else begin
      ir_r <= ir_r;
    end
  end

  // A/D writeback at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= 16'h0000;
      d_r <= 16'h0000;
    end else if (exec_s) begin
      if (!is_c_s) begin
        a_r <= {1'b0, ir_r[14:0]};
        d_r <= d_r;
      end else begin
        a_r <= ir_r[D1] ? alu_out_s : a_r;
        d_r <= ir_r[D2] ? alu_out_s : d_r;
      end
    end else begin
      a_r <= a_r;
      d_r <= d_r;
    end
  end

endmodule
